chunk_serial_addsub: RTL and testbench

//  Parametrised multi-cycle adder/subtractor. Successor to the 8-bit ripple adder.

---
 rtl/chunk_serial_addsub.sv | 149 ++++++++++++++
 tb/tb_chunk_serial_addsub.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/chunk_serial_addsub.sv
// chunk_serial_addsub: multi-cycle add/sub that handles CHUNK bits per clock, LSB chunk first.
// Optional ADDSUB_SAT_EN clamps the result to the signed limit on overflow.  Rev 1.0
`default_nettype none

module chunk_serial_addsub #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iStart,
  input  logic             iSub,
  input  logic [WIDTH-1:0] iData_a,
  input  logic [WIDTH-1:0] iData_b,
  input  logic             iC,
  output logic             oBusy,
  output logic             oDone,
  output logic [WIDTH-1:0] oData,
  output logic             oData_C,
  output logic             oOvf
);

  localparam int c_N     = WIDTH / CHUNK;
  localparam int c_CNT_W = (c_N > 1) ? $clog2(c_N) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_N - 1);
  localparam logic [WIDTH-1:0]   c_SMIN = WIDTH'(1) << (WIDTH - 1);
  localparam logic [WIDTH-1:0]   c_SMAX = ~c_SMIN;

  if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
    $error("chunk_serial_addsub: WIDTH must be a positive multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_acc;
  logic               r_carry;
  logic               r_a_msb;
  logic               r_b_msb;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_data;
  logic               r_data_c;
  logic               r_ovf;

  logic [CHUNK:0]     w_sum;
  logic [WIDTH-1:0]   w_acc_next;
  logic [WIDTH-1:0]   w_a_shift;
  logic [WIDTH-1:0]   w_b_shift;
  logic               w_ovf;
  logic [WIDTH-1:0]   w_result;

  // Operands shift right each RUN cycle so the active chunk always sits at bit 0;
  // the accumulator fills from the top, landing the LSB chunk at bit 0 after N cycles.
  assign w_sum = {1'b0, r_a[CHUNK-1:0]} + {1'b0, r_b[CHUNK-1:0]} + {{CHUNK{1'b0}}, r_carry};

  if (c_N == 1) begin : g_single
    assign w_acc_next = w_sum[CHUNK-1:0];
    assign w_a_shift  = '0;
    assign w_b_shift  = '0;
  end else begin : g_multi
    assign w_acc_next = {w_sum[CHUNK-1:0], r_acc[WIDTH-1:CHUNK]};
    assign w_a_shift  = {{CHUNK{1'b0}}, r_a[WIDTH-1:CHUNK]};
    assign w_b_shift  = {{CHUNK{1'b0}}, r_b[WIDTH-1:CHUNK]};
  end

  assign w_ovf = (r_a_msb == r_b_msb) && (w_acc_next[WIDTH-1] != r_a_msb);

`ifdef ADDSUB_SAT_EN
  assign w_result = w_ovf ? (r_a_msb ? c_SMIN : c_SMAX) : w_acc_next;
`else
  assign w_result = w_acc_next;
`endif

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_carry  <= 1'b0;
      r_a_msb  <= 1'b0;
      r_b_msb  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_data   <= '0;
      r_data_c <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (iStart) begin
            // Subtraction is a + ~b + ~borrow, so only the operand and carry are inverted.
            r_a     <= iData_a;
            r_b     <= iSub ? ~iData_b : iData_b;
            r_carry <= iSub ? ~iC : iC;
            r_a_msb <= iData_a[WIDTH-1];
            r_b_msb <= iSub ? ~iData_b[WIDTH-1] : iData_b[WIDTH-1];
            r_acc   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_acc   <= w_acc_next;
          r_a     <= w_a_shift;
          r_b     <= w_b_shift;
          r_carry <= w_sum[CHUNK];
          if (r_cnt == c_LAST) begin
            r_cnt    <= '0;
            r_data   <= w_result;
            r_data_c <= w_sum[CHUNK];
            r_ovf    <= w_ovf;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign oBusy   = r_busy;
  assign oDone   = r_done;
  assign oData   = r_data;
  assign oData_C = r_data_c;
  assign oOvf    = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_chunk_serial_addsub.sv
// tb_chunk_serial_addsub: table-driven and scoreboard bench for chunk_serial_addsub.
`default_nettype none

module tb_chunk_serial_addsub;

  localparam int W  = 8;
  localparam int CH = 2;
  localparam int N  = W / CH;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         iStart = 1'b0, iSub = 1'b0, iC = 1'b0;
  logic [W-1:0] iData_a = '0, iData_b = '0;
  logic         oBusy, oDone, oData_C, oOvf;
  logic [W-1:0] oData;

  logic         iStart2 = 1'b0, iSub2 = 1'b0, iC2 = 1'b0;
  logic [W-1:0] iData_a2 = '0, iData_b2 = '0;
  logic         oBusy2, oDone2, oData_C2, oOvf2;
  logic [W-1:0] oData2;

  chunk_serial_addsub #(.WIDTH(W), .CHUNK(CH)) u_dut (
    .iClk(clk), .iRst(rst), .iStart(iStart), .iSub(iSub),
    .iData_a(iData_a), .iData_b(iData_b), .iC(iC),
    .oBusy(oBusy), .oDone(oDone), .oData(oData), .oData_C(oData_C), .oOvf(oOvf)
  );

  chunk_serial_addsub #(.WIDTH(W), .CHUNK(W)) u_dut1 (
    .iClk(clk), .iRst(rst), .iStart(iStart2), .iSub(iSub2),
    .iData_a(iData_a2), .iData_b(iData_b2), .iC(iC2),
    .oBusy(oBusy2), .oDone(oDone2), .oData(oData2), .oData_C(oData_C2), .oOvf(oOvf2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c;
    logic [W-1:0] d;
    logic         co;
    logic         ov;
  } vec_t;

  typedef struct {
    logic [W-1:0] d;
    logic         co;
    logic         ov;
    int           t0;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   busy_cnt = 0;
  int   done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] sat_of(input logic [W-1:0] d, input logic ov, input logic amsb);
`ifdef ADDSUB_SAT_EN
    if (ov) return amsb ? 8'h80 : 8'h7F;
`endif
    return d;
  endfunction

  // Reference: one full-width addition, independent of chunking.
  function automatic vec_t model(input logic sub, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic c);
    vec_t         v;
    logic [W-1:0] bb;
    logic [W:0]   s;
    bb = sub ? ~b : b;
    s  = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (sub ? ~c : c)};
    v.sub = sub; v.a = a; v.b = b; v.c = c;
    v.d  = s[W-1:0];
    v.co = s[W];
    v.ov = (a[W-1] == bb[W-1]) && (s[W-1] != a[W-1]);
    return v;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst) busy_cnt = 0;
    else if (oBusy) busy_cnt++;
    if (oDone) begin
      done_cnt++;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got oDone=1 expected no pending op (t=%0t)", $time);
      end else begin
        e = sb.pop_front();
        chk("data", oData, e.d);
        chk("carry", oData_C, e.co);
        chk("ovf", oOvf, e.ov);
        chk("latency", cyc - e.t0, N);
        chk("busy_cycles", busy_cnt, N);
      end
      busy_cnt = 0;
    end
  end

  task automatic run_op(input vec_t v);
    exp_t e;
    @(negedge clk);
    iSub = v.sub; iData_a = v.a; iData_b = v.b; iC = v.c; iStart = 1'b1;
    @(posedge clk);
    #1;
    e.d  = sat_of(v.d, v.ov, v.a[W-1]);
    e.co = v.co;
    e.ov = v.ov;
    e.t0 = cyc;
    sb.push_back(e);
    iStart = 1'b0;
    // Operand changes after the start edge must not disturb the op.
    iData_a = W'($urandom); iData_b = W'($urandom); iSub = 1'($urandom); iC = 1'($urandom);
    for (int k = 0; k < 4 * N && sb.size() != 0; k++) begin
      @(negedge clk);
      #1;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: got no oDone expected one within %0d cycles", 4 * N);
      sb.delete();
    end
  endtask

  vec_t tbl[12];
  vec_t v;

  initial begin
    tbl[0]  = '{1'b0, 8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1};
    tbl[1]  = '{1'b0, 8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 8'h10, 8'h20, 1'b0, 8'hF0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1};
    tbl[4]  = '{1'b0, 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1};
    tbl[5]  = '{1'b1, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 8'h00, 8'h00, 1'b1, 8'hFF, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 8'hC0, 8'hC0, 1'b0, 8'h80, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    tbl[11] = '{1'b1, 8'h55, 8'hAA, 1'b1, 8'hAA, 1'b0, 1'b1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", oBusy, 0);
    chk("rst_done", oDone, 0);
    chk("rst_data", oData, 0);
    chk("rst_carry", oData_C, 0);
    chk("rst_ovf", oOvf, 0);
    chk("rst_n1_data", {oBusy2, oDone2, oData2, oData_C2, oOvf2}, 0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) run_op(tbl[i]);

    for (int i = 0; i < 16; i++) begin
      v = model(1'($urandom), W'($urandom), W'($urandom), 1'($urandom));
      run_op(v);
    end

    // Result must hold after DONE until the next completion.
    run_op(tbl[3]);
    repeat (3) @(negedge clk);
    chk("hold_data", oData, sat_of(8'h7F, 1'b1, 1'b1));
    chk("hold_carry", oData_C, 1);
    chk("hold_ovf", oOvf, 1);

    // Restart attempt in RUN, then reset mid-op: op is dropped, outputs cleared.
    @(negedge clk);
    iSub = 1'b0; iData_a = 8'h12; iData_b = 8'h34; iC = 1'b0; iStart = 1'b1;
    @(posedge clk);
    #1 iStart = 1'b0;
    @(negedge clk);
    iStart = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iStart = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", oBusy, 0);
    chk("midrst_done", oDone, 0);
    chk("midrst_data", oData, 0);
    chk("midrst_carry", oData_C, 0);
    chk("midrst_ovf", oOvf, 0);
    rst = 1'b0;
    begin
      int d0;
      d0 = done_cnt;
      repeat (10) @(negedge clk);
      chk("midrst_no_done", done_cnt - d0, 0);
      chk("midrst_idle_busy", oBusy, 0);
    end

    // Single-chunk instance, start held high: back-to-back every 2 cycles.
    @(negedge clk);
    iData_a2 = 8'h01; iData_b2 = 8'h01; iSub2 = 1'b0; iC2 = 1'b0; iStart2 = 1'b1;
    @(posedge clk);
    #1;
    iData_a2 = 8'h7F; iData_b2 = 8'h01;
    @(negedge clk);
    chk("n1_busy_run", oBusy2, 1);
    chk("n1_done_run", oDone2, 0);
    @(negedge clk);
    chk("n1_done1", oDone2, 1);
    chk("n1_data1", oData2, 8'h02);
    chk("n1_ovf1", oOvf2, 0);
    @(negedge clk);
    chk("n1_gap_done", oDone2, 0);
    chk("n1_gap_busy", oBusy2, 1);
    iStart2 = 1'b0;
    @(negedge clk);
    chk("n1_done2", oDone2, 1);
    chk("n1_data2", oData2, sat_of(8'h80, 1'b1, 1'b0));
    chk("n1_carry2", oData_C2, 0);
    chk("n1_ovf2", oOvf2, 1);
    @(negedge clk);
    chk("n1_idle_done", oDone2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected completion");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
